morse_alpha_decoder: RTL and testbench

//   Decodes a stream of classified Morse symbols into ASCII characters, one character per letter.
//   The upstream timing classifier supplies one symbol code per clock.
//   A tree-walking FSM tracks the partial dit/dah sequence.
//   On a letter gap or word space it emits the ASCII code with a one-cycle done strobe to the downstream text buffer.

---
 rtl/morse_pkg.sv | 28 ++
 rtl/morse_rom.sv | 56 +++++
 rtl/morse_alpha_decoder.sv | 76 +++++++
 tb/tb_morse_alpha_decoder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared constants for the Morse decoder: symbol codes, special ASCII values,
// tree node constants and the depth limit. Build option: MORSE_DIGITS_EN.
package morse_pkg;

   localparam int unsigned SYM_W  = 3;
   localparam int unsigned NODE_W = 6;
   localparam int unsigned CHAR_W = 8;

   localparam logic [SYM_W-1:0] SYM_WAIT  = 3'd0;
   localparam logic [SYM_W-1:0] SYM_DIT   = 3'd1;
   localparam logic [SYM_W-1:0] SYM_DAH   = 3'd2;
   localparam logic [SYM_W-1:0] SYM_GAP   = 3'd3;
   localparam logic [SYM_W-1:0] SYM_SPACE = 3'd4;

   localparam logic [CHAR_W-1:0] ASCII_SPACE = 8'h20;
   localparam logic [CHAR_W-1:0] ASCII_UNK   = 8'h3F;

   localparam logic [NODE_W-1:0] ROOT = 6'd1;
   localparam logic [NODE_W-1:0] ERR  = 6'd0;

   // First node index of the deepest allowed level; a further symbol from here overflows.
`ifdef MORSE_DIGITS_EN
   localparam logic [NODE_W-1:0] FIRST_LEAF = 6'd32;
`else
   localparam logic [NODE_W-1:0] FIRST_LEAF = 6'd16;
`endif

endpackage

// File: rtl/morse_rom.sv
// Heap-indexed Morse tree node to ASCII lookup. Digit nodes (depth 5) are
// included only when MORSE_DIGITS_EN is defined; anything unmapped is '?'.
module morse_rom
   import morse_pkg::*;
(
   input  logic [NODE_W-1:0] node,
   output logic [CHAR_W-1:0] ascii_c
);

   // Pure table lookup, '?' for holes in the tree.
   always_comb begin
      ascii_c = ASCII_UNK;
      case (node)
         6'd2:  ascii_c = 8'h45; // E
         6'd3:  ascii_c = 8'h54; // T
         6'd4:  ascii_c = 8'h49; // I
         6'd5:  ascii_c = 8'h41; // A
         6'd6:  ascii_c = 8'h4E; // N
         6'd7:  ascii_c = 8'h4D; // M
         6'd8:  ascii_c = 8'h53; // S
         6'd9:  ascii_c = 8'h55; // U
         6'd10: ascii_c = 8'h52; // R
         6'd11: ascii_c = 8'h57; // W
         6'd12: ascii_c = 8'h44; // D
         6'd13: ascii_c = 8'h4B; // K
         6'd14: ascii_c = 8'h47; // G
         6'd15: ascii_c = 8'h4F; // O
         6'd16: ascii_c = 8'h48; // H
         6'd17: ascii_c = 8'h56; // V
         6'd18: ascii_c = 8'h46; // F
         6'd20: ascii_c = 8'h4C; // L
         6'd22: ascii_c = 8'h50; // P
         6'd23: ascii_c = 8'h4A; // J
         6'd24: ascii_c = 8'h42; // B
         6'd25: ascii_c = 8'h58; // X
         6'd26: ascii_c = 8'h43; // C
         6'd27: ascii_c = 8'h59; // Y
         6'd28: ascii_c = 8'h5A; // Z
         6'd29: ascii_c = 8'h51; // Q
`ifdef MORSE_DIGITS_EN
         6'd32: ascii_c = 8'h35; // 5
         6'd33: ascii_c = 8'h34; // 4
         6'd35: ascii_c = 8'h33; // 3
         6'd39: ascii_c = 8'h32; // 2
         6'd47: ascii_c = 8'h31; // 1
         6'd48: ascii_c = 8'h36; // 6
         6'd56: ascii_c = 8'h37; // 7
         6'd60: ascii_c = 8'h38; // 8
         6'd62: ascii_c = 8'h39; // 9
         6'd63: ascii_c = 8'h30; // 0
`endif
         default: ascii_c = ASCII_UNK;
      endcase
   end

endmodule

// File: rtl/morse_alpha_decoder.sv
// Morse symbol stream to ASCII decoder. Walks a heap-indexed tree on DIT/DAH
// and emits one character with a one-cycle done strobe on GAP/SPACE.
// Build option: MORSE_DIGITS_EN enables a fifth tree level for digits.
module morse_alpha_decoder
   import morse_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [SYM_W-1:0]  inputSignal,
   output logic              done,
   output logic [CHAR_W-1:0] letter
);

   logic [NODE_W-1:0] state;
   logic [NODE_W-1:0] state_d;
   logic              done_q;
   logic              done_d;
   logic [CHAR_W-1:0] letter_q;
   logic [CHAR_W-1:0] letter_d;
   logic [CHAR_W-1:0] rom_char_c;

   morse_rom u_rom (
      .node    (state),
      .ascii_c (rom_char_c)
   );

   // Tree walk and emission decision for the current symbol.
   always_comb begin
      state_d  = state;
      done_d   = 1'b0;
      letter_d = letter_q;
      case (inputSignal)
         SYM_DIT, SYM_DAH: begin
            // ERR absorbs symbols; stepping past the deepest level falls into ERR.
            if (state == ERR) begin
               state_d = ERR;
            end else if (state >= FIRST_LEAF) begin
               state_d = ERR;
            end else begin
               state_d = {state[NODE_W-2:0], (inputSignal == SYM_DAH)};
            end
         end
         SYM_GAP, SYM_SPACE: begin
            if (state != ROOT) begin
               // Pending letter (or error) is flushed; a trailing word space is dropped.
               letter_d = (state == ERR) ? ASCII_UNK : rom_char_c;
               done_d   = 1'b1;
               state_d  = ROOT;
            end else if (inputSignal == SYM_SPACE) begin
               letter_d = ASCII_SPACE;
               done_d   = 1'b1;
            end
         end
         default: begin
            state_d = state;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ROOT;
         done_q   <= 1'b0;
         letter_q <= 8'h00;
      end else begin
         state    <= state_d;
         done_q   <= done_d;
         letter_q <= letter_d;
      end
   end

   assign done   = done_q;
   assign letter = letter_q;

endmodule

// File: tb/tb_morse_alpha_decoder.sv
// Self-checking bench for morse_alpha_decoder. Reference decode is by Morse
// string lookup; expected characters flow through a scoreboard queue.
module tb_morse_alpha_decoder;
   import morse_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] inputSignal;
   logic       done;
   logic [7:0] letter;

   morse_alpha_decoder dut (
      .clk         (clk),
      .reset       (reset),
      .inputSignal (inputSignal),
      .done        (done),
      .letter      (letter)
   );

   always #5 clk = ~clk;

`ifdef MORSE_DIGITS_EN
   localparam int MAXD = 5;
`else
   localparam int MAXD = 4;
`endif

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] last_letter;
   string      seq;
   bit         err;

   string letter_codes [26] = '{".-","-...","-.-.","-..",".","..-.","--.","....","..",
                                ".---","-.-",".-..","--","-.","---",".--.","--.-",".-.",
                                "...","-","..-","...-",".--","-..-","-.--","--.."};
   string digit_codes [10] = '{"-----",".----","..---","...--","....-",".....",
                               "-....","--...","---..","----."};

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_char(input string s);
      logic [7:0] c;
      c = 8'h3F;
      for (int i = 0; i < 26; i++)
         if (s == letter_codes[i]) c = 8'(8'h41 + i);
`ifdef MORSE_DIGITS_EN
      for (int i = 0; i < 10; i++)
         if (s == digit_codes[i]) c = 8'(8'h30 + i);
`endif
      return c;
   endfunction

   // Drive one symbol, update the reference, then check the cycle's outputs.
   task automatic send(input logic [2:0] sym);
      bit         emit;
      logic [7:0] e;
      emit = 1'b0;
      e    = 8'h00;
      if (sym == SYM_DIT || sym == SYM_DAH) begin
         if (!err) begin
            if (seq.len() >= MAXD) err = 1'b1;
            else seq = {seq, (sym == SYM_DIT) ? "." : "-"};
         end
      end else if (sym == SYM_GAP || sym == SYM_SPACE) begin
         if (err || seq.len() > 0) begin
            emit = 1'b1;
            e    = err ? 8'h3F : ref_char(seq);
         end else if (sym == SYM_SPACE) begin
            emit = 1'b1;
            e    = 8'h20;
         end
         seq = "";
         err = 1'b0;
      end
      if (emit) exp_q.push_back(e);
      inputSignal = sym;
      @(posedge clk);
      #1;
      check_val("done", 32'(done), 32'(emit));
      if (done) begin
         if (exp_q.size() == 0) check_val("sb_underflow", 32'(exp_q.size()), 32'd1);
         else check_val("letter", 32'(letter), 32'(exp_q.pop_front()));
         last_letter = letter;
      end else begin
         check_val("letter_hold", 32'(letter), 32'(last_letter));
      end
   endtask

   task automatic do_reset(input logic [2:0] sym);
      reset       = 1'b1;
      inputSignal = sym;
      @(posedge clk);
      #1;
      check_val("rst_state", 32'(dut.state), 32'd1);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_letter", 32'(letter), 32'h00);
      reset       = 1'b0;
      seq         = "";
      err         = 1'b0;
      last_letter = 8'h00;
      exp_q.delete();
   endtask

   initial begin
      reset       = 1'b0;
      inputSignal = SYM_WAIT;
      seq         = "";
      err         = 1'b0;
      last_letter = 8'h00;
      #2;
      do_reset(SYM_WAIT);

      // 1: E, then hold
      send(SYM_DIT); send(SYM_GAP);
      check_val("t1_E", 32'(letter), 32'h45);
      send(SYM_WAIT); send(SYM_WAIT);

      // 2: B with state trace
      send(SYM_DAH); check_val("t2_s3", 32'(dut.state), 32'd3);
      send(SYM_DIT); check_val("t2_s6", 32'(dut.state), 32'd6);
      send(SYM_DIT); check_val("t2_s12", 32'(dut.state), 32'd12);
      send(SYM_DIT); check_val("t2_s24", 32'(dut.state), 32'd24);
      send(SYM_GAP);
      check_val("t2_B", 32'(letter), 32'h42);
      check_val("t2_root", 32'(dut.state), 32'd1);

      // 3: spaces
      send(SYM_SPACE); check_val("t3_sp", 32'(letter), 32'h20);
      send(SYM_WAIT);
      send(SYM_DIT); send(SYM_SPACE); check_val("t3_E", 32'(letter), 32'h45);
      send(SYM_SPACE); send(SYM_SPACE);

      // 4: hole node 19, GAP at root, reserved codes mid-letter
      send(SYM_DIT); send(SYM_DIT); send(SYM_DAH); send(SYM_DAH); send(SYM_GAP);
      check_val("t4_q", 32'(letter), 32'h3F);
      send(SYM_GAP);
      send(SYM_DAH); send(3'd5); send(3'd6); send(3'd7); send(SYM_DAH); send(SYM_GAP);
      check_val("t4_M", 32'(letter), 32'h4D);

      // 5: five DITs
      for (int i = 0; i < 5; i++) send(SYM_DIT);
      send(SYM_GAP);
`ifdef MORSE_DIGITS_EN
      check_val("t5_5", 32'(letter), 32'h35);
`else
      check_val("t5_err", 32'(letter), 32'h3F);
`endif
      // six symbols always overflow
      for (int i = 0; i < 6; i++) send(SYM_DAH);
      check_val("t5_errstate", 32'(dut.state), 32'd0);
      send(SYM_SPACE);

      // 6: reset mid-letter has priority over a symbol
      send(SYM_DAH);
      do_reset(SYM_DIT);
      send(SYM_DIT); send(SYM_GAP);
      check_val("t6_E", 32'(letter), 32'h45);

      // random mix against the reference
      for (int i = 0; i < 400; i++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 4) send(SYM_DIT);
         else if (r < 7) send(SYM_DAH);
         else if (r == 7) send(SYM_GAP);
         else if (r == 8) send(SYM_SPACE);
         else send(3'($urandom_range(0, 7) | 0) == SYM_DIT ? SYM_WAIT : 3'd6);
      end
      send(SYM_GAP);
      check_val("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
